// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared state encoding, byte width and register bundle for spi_slave_serdes
package spi_slave_pkg;
    localparam int BYTE_W = 8;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_XFER = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, LOAD = ST_LOAD, XFER = ST_XFER} state_t;
    typedef struct packed {
        state_t st;
        logic [2:0] bit_cnt;
        logic [BYTE_W-1:0] tx_sh, hold, rx_sh, rx_data;
        logic hold_full, rx_valid, load_pend, first, spe_q, ovr, unr, abt;
    } regs_t;
    localparam regs_t REGS_RST = '{st: IDLE, bit_cnt: 3'd0, tx_sh: 8'hFF, hold: 8'h00,
                                   rx_sh: 8'h00, rx_data: 8'h00, hold_full: 1'b0,
                                   rx_valid: 1'b0, load_pend: 1'b0, first: 1'b0,
                                   spe_q: 1'b0, ovr: 1'b0, unr: 1'b0, abt: 1'b0};
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizer plus registered edge detect for one SPI pin
//   Bus_CLK_i, RST_i (async), RST_SYNC_i (sync clear)
//   pin   : asynchronous pin input
//   level : synchronized level, aligned with the rise/fall pulses
//   rise  : one-cycle pulse on a 0->1 transition
//   fall  : one-cycle pulse on a 1->0 transition
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic Bus_CLK_i,
    input  logic RST_i,
    input  logic RST_SYNC_i,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] s;

    always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
        if (RST_i || RST_SYNC_i) begin
            s    <= {3{RST_VAL}};
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s    <= {s[1:0], pin};
            rise <= s[1] & ~s[2];
            fall <= ~s[1] & s[2];
        end
    end

    assign level = s[2];
endmodule

// File: rtl/spi_slave_serdes.sv
// spi_slave_serdes: SPI target serializer/deserializer oversampled in the Bus_CLK_i domain
//   Pins      : SCK_i, SSn_i, MOSI_i in; MISO_o, MISO_OEn_o out
//   Mode      : CPOL_i, CPHA_i, LSBFE_i, SPE_i
//   TX        : TX_Data_i/TX_Valid_i/TX_Ready_o into a one-byte holding register
//   RX        : RX_Data_o/RX_Valid_o held until RX_Ack_i
//   Events    : RX_Overrun_o, TX_Underrun_o, Abort_o one-cycle pulses; Busy_o
module spi_slave_serdes import spi_slave_pkg::*; (
    input  logic              Bus_CLK_i,
    input  logic              RST_i,
    input  logic              RST_SYNC_i,
    input  logic              SPE_i,
    input  logic              CPOL_i,
    input  logic              CPHA_i,
    input  logic              LSBFE_i,
    input  logic              SCK_i,
    input  logic              SSn_i,
    input  logic              MOSI_i,
    output logic              MISO_o,
    output logic              MISO_OEn_o,
    input  logic [BYTE_W-1:0] TX_Data_i,
    input  logic              TX_Valid_i,
    output logic              TX_Ready_o,
    output logic [BYTE_W-1:0] RX_Data_o,
    output logic              RX_Valid_o,
    input  logic              RX_Ack_i,
    output logic              RX_Overrun_o,
    output logic              TX_Underrun_o,
    output logic              Abort_o,
    output logic              Busy_o
);
    regs_t r, n;
    logic sck_rise, sck_fall, ss_rise, ss_fall, mosi;
    logic sck_lvl_unused, ss_lvl_unused, mosi_unused_r, mosi_unused_f;
    logic lead, trail, smp, shf, stop, ld, do_shift, tx_hs, done;
    logic [BYTE_W-1:0] rx_nxt;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sck (.Bus_CLK_i(Bus_CLK_i), .RST_i(RST_i), .RST_SYNC_i(RST_SYNC_i),
        .pin(SCK_i), .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
    spi_pin_sync #(.RST_VAL(1'b1)) u_ss (.Bus_CLK_i(Bus_CLK_i), .RST_i(RST_i), .RST_SYNC_i(RST_SYNC_i),
        .pin(SSn_i), .level(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall));
    spi_pin_sync #(.RST_VAL(1'b0)) u_mosi (.Bus_CLK_i(Bus_CLK_i), .RST_i(RST_i), .RST_SYNC_i(RST_SYNC_i),
        .pin(MOSI_i), .level(mosi), .rise(mosi_unused_r), .fall(mosi_unused_f));

    assign lead  = CPOL_i ? sck_fall : sck_rise;
    assign trail = CPOL_i ? sck_rise : sck_fall;
    assign smp   = (CPHA_i ? trail : lead) && r.st == XFER && SPE_i;
    assign shf   = (CPHA_i ? lead : trail) && r.st == XFER && SPE_i;
    assign stop  = ss_rise || !SPE_i;
    // CPHA=1: the first shift edge of a byte reloads, except for the first byte which LOAD already filled.
    // CPHA=0: the shift edge right after the 8th sample reloads instead of rotating.
    assign ld       = r.st == LOAD || (shf && (CPHA_i ? (r.bit_cnt == 3'd0 && !r.first) : r.load_pend));
    assign do_shift = shf && !(CPHA_i ? r.bit_cnt == 3'd0 : r.load_pend);
    assign tx_hs    = TX_Valid_i && !r.hold_full;
    assign rx_nxt   = LSBFE_i ? {mosi, r.rx_sh[BYTE_W-1:1]} : {r.rx_sh[BYTE_W-2:0], mosi};
    assign done     = smp && r.bit_cnt == 3'd7;

    always_comb begin
        n           = r;
        n.st        = !SPE_i ? IDLE : (r.st == IDLE && ss_fall) ? LOAD : (r.st == LOAD) ? XFER
                    : (r.st == XFER && ss_rise) ? IDLE : r.st;
        n.hold_full = ld ? tx_hs : (r.hold_full || tx_hs);
        n.hold      = tx_hs ? TX_Data_i : r.hold;
        n.tx_sh     = ld ? (r.hold_full ? r.hold : 8'hFF)
                    : !do_shift ? r.tx_sh
                    : LSBFE_i ? {r.tx_sh[0], r.tx_sh[BYTE_W-1:1]} : {r.tx_sh[BYTE_W-2:0], r.tx_sh[BYTE_W-1]};
        n.unr       = ld && !r.hold_full;
        n.first     = r.st == LOAD ? 1'b1 : (shf && CPHA_i) ? 1'b0 : r.first;
        n.load_pend = (stop || r.st != XFER) ? 1'b0 : (done && !CPHA_i) ? 1'b1 : shf ? 1'b0 : r.load_pend;
        n.rx_sh     = smp ? rx_nxt : r.rx_sh;
        n.bit_cnt   = (stop || r.st == IDLE) ? 3'd0 : smp ? r.bit_cnt + 3'd1 : r.bit_cnt;
        n.rx_data   = done ? rx_nxt : r.rx_data;
        n.rx_valid  = done || (r.rx_valid && !RX_Ack_i);
        n.ovr       = done && r.rx_valid && !RX_Ack_i;
        n.abt       = (ss_rise || (r.spe_q && !SPE_i)) && r.bit_cnt != 3'd0;
        n.spe_q     = SPE_i;
    end

    always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
        if (RST_i) r <= REGS_RST;
        else       r <= RST_SYNC_i ? REGS_RST : n;
    end

    assign MISO_o        = LSBFE_i ? r.tx_sh[0] : r.tx_sh[BYTE_W-1];
    assign MISO_OEn_o    = r.st == IDLE;
    assign TX_Ready_o    = !r.hold_full;
    assign RX_Data_o     = r.rx_data;
    assign RX_Valid_o    = r.rx_valid;
    assign RX_Overrun_o  = r.ovr;
    assign TX_Underrun_o = r.unr;
    assign Abort_o       = r.abt;
    assign Busy_o        = r.st != IDLE;
endmodule
